tick_updown_counter: RTL and testbench
======================================

Name: tick_updown_counter

Overview:
- Parametrised, fully synchronous modulo-N up/down counter with a built-in prescaler.
- Replaces the divided-clock plus ripple-DFF arrangement: the prescaler produces a one-cycle enable tick, and every flop runs on the single system clock.
- Adds direction control, synchronous load, wrap or saturate mode, and a terminal-count pulse.
- Sits between the board clock and the LED/7-seg display logic.

Parameters:
WIDTH, 4, count register width in bits; legal range 1..32.
MODULUS, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH.
DIV, 62500000, system clocks per count step; legal minimum 1.
SATURATE, 0, 0 = wrap at the ends of the range, 1 = hold at the ends.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset.
en  input  1  run enable; prescaler and counter freeze while it is low.
up  input  1  direction: 1 = increment, 0 = decrement; sampled on tick.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value to load.
count  output  WIDTH  current count, registered.
tick  output  1  prescaler step strobe, combinational.
tc  output  1  terminal-count pulse, registered.

Behaviour:
- Reset:
  - rst low clears count, prescaler and tc to 0 immediately, without waiting for a clock edge.
  - tick is 0 while in reset.
  - Deassertion takes effect at the next clk edge.
  - Reset during a count sequence abandons it; there is no resume.
- Prescaler:
  - Internal counter pre, width max(1, clog2(DIV)).
  - When en=1: pre counts 0..DIV-1 and wraps to 0.
  - When en=0: pre holds.
- Tick:
  - tick = en && (pre == DIV-1).
  - When DIV=1, tick = en.
  - First tick after reset or load is DIV cycles after en goes high.
- Count step: on a clock edge with tick=1 and load=0:
  - up=1, count<MODULUS-1: count+1.
  - up=1, count==MODULUS-1: goes to 0 (SATURATE=0) or holds (SATURATE=1).
  - up=0, count>0: count-1.
  - up=0, count==0: goes to MODULUS-1 (SATURATE=0) or holds (SATURATE=1).
- tc:
  - Registered, high for exactly one cycle after any tick edge where count was at the end of the range in the current direction (MODULUS-1 going up, 0 going down).
  - This applies in both modes.
  - In SATURATE mode it re-pulses on every tick while the count is held at the end.
  - Otherwise tc is 0.
- Load:
  - Has priority over tick and takes effect regardless of en.
  - count <= load_val; a load_val >= MODULUS is clamped to MODULUS-1.
  - pre <= 0; tc <= 0 that cycle.
  - If load and tick coincide, the load wins and the step is discarded.
- Direction:
  - A change of up takes effect on the next tick.
  - There is no glitch in count and no spurious tc.
- en low mid-period:
  - pre, count and tc stay frozen; tc drops after its single pulse cycle.
  - When en returns, the period resumes from the held pre value.
- Arithmetic:
  - Unsigned, modulo MODULUS.
  - count never leaves 0..MODULUS-1 after reset or load.
- Latency: count changes on the same edge that samples tick=1, so a new value is visible one cycle after the tick cycle.

Test Plan:
1. DIV=4, MODULUS=10, SATURATE=0; en=1, up=1 from reset -> tick every 4th cycle; count 0,1,...,9,0; tc high for the one cycle after 9->0; exactly 40 cycles per revolution.
2. Same configuration, up=0 from reset -> first step 0->9 with a tc pulse; then 8,7,...,0; tc pulses again on 0->9.
3. SATURATE=1, MODULUS=10; count up past 9 -> count holds at 9 and tc pulses on every tick; switch to up=0 -> next tick gives 8, tc=0.
4. load=1, load_val=5 on the same edge as a tick -> count=5 (no step); next tick at 4 cycles later gives 6. Then load_val=15 -> count=9 (clamped).
5. en low for 7 cycles with pre=2 -> count, pre and tick frozen. After en=1, the next tick arrives 2 cycles later.
6. Assert rst low asynchronously between clock edges while count=7 and tc=1 -> count=0 and tc=0 immediately. After release, the first tick comes DIV cycles later.

Source files
------------

// File: rtl/tick_updown_counter.sv
// tick_updown_counter
//   Fully synchronous modulo-MODULUS up/down counter with a built-in
//   prescaler. The prescaler produces a one-cycle enable strobe (tick) every
//   DIV enabled clocks. Every flop runs on clk; no derived clocks.
//
// Ports
//   clk       system clock, all state updates on its rising edge
//   rst       asynchronous active-low reset
//   en        run enable; prescaler and counter freeze while low
//   up        direction: 1 = increment, 0 = decrement (sampled on tick)
//   load      synchronous load strobe, priority over tick, ignores en
//   load_val  value to load (clamped to MODULUS-1)
//   count     current count, registered
//   tick      prescaler step strobe, combinational
//   tc        terminal-count pulse, registered
module tick_updown_counter #(
  parameter int unsigned      WIDTH    = 4,
  parameter longint unsigned  MODULUS  = 16,
  parameter int unsigned      DIV      = 62500000,
  parameter int unsigned      SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  localparam int unsigned     PRE_W   = (DIV <= 1) ? 1 : $clog2(DIV);
  localparam longint unsigned DIV_M1  = DIV - 1;
  localparam longint unsigned MOD_M1  = MODULUS - 1;

  localparam logic [PRE_W-1:0] PRE_LAST = DIV_M1[PRE_W-1:0];
  localparam logic [WIDTH-1:0] MAX_VAL  = MOD_M1[WIDTH-1:0];
  // One extra bit so MODULUS == 2**WIDTH is representable for the clamp test.
  localparam logic [WIDTH:0]   MOD_EXT  = MODULUS[WIDTH:0];

  logic [PRE_W-1:0] pre;
  logic             at_end;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_clamped;

  // Held in reset, tick must read 0 even though pre already sits at 0
  // (which equals PRE_LAST when DIV == 1).
  assign tick = rst & en & (pre == PRE_LAST);

  always_comb begin
    at_end     = 1'b0;
    next_count = count;
    if (up) begin
      at_end = (count == MAX_VAL);
      if (!at_end)            next_count = count + 1'b1;
      else if (SATURATE == 0) next_count = '0;
    end else begin
      at_end = (count == '0);
      if (!at_end)            next_count = count - 1'b1;
      else if (SATURATE == 0) next_count = MAX_VAL;
    end
  end

  always_comb begin
    load_clamped = load_val;
    if ({1'b0, load_val} >= MOD_EXT) load_clamped = MAX_VAL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre   <= '0;
      count <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      pre   <= '0;
      count <= load_clamped;
      tc    <= 1'b0;
    end else begin
      tc <= tick & at_end;
      if (en) begin
        pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      end
      if (tick) begin
        count <= next_count;
      end
    end
  end

endmodule

// File: tb/tb_tick_updown_counter.sv
// Testbench for tick_updown_counter: three instances (wrap DIV=4 MOD=10,
// saturate DIV=4 MOD=10, wrap DIV=1 MOD=16) share stimulus and are compared
// every cycle against an arithmetic reference model.
module tb_tick_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] lv;

  logic [3:0] cnt_o  [3];
  logic       tick_o [3];
  logic       tc_o   [3];

  int checks = 0;
  int errors = 0;

  int DIVS [3] = '{4, 4, 1};
  int MODS [3] = '{10, 10, 16};
  int SATS [3] = '{0, 1, 0};

  // Reference state: count, enabled cycles since last sync, tc.
  int m_cnt [3];
  int m_n   [3];
  int m_tc  [3];

  always #5 clk = ~clk;

  tick_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .count(cnt_o[0]), .tick(tick_o[0]), .tc(tc_o[0]));

  tick_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .count(cnt_o[1]), .tick(tick_o[1]), .tc(tc_o[1]));

  tick_updown_counter #(.WIDTH(4), .MODULUS(16), .DIV(1), .SATURATE(0)) u_fast (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .count(cnt_o[2]), .tick(tick_o[2]), .tc(tc_o[2]));

  task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s[%0d] observed %0d expected %0d", tag, idx, obs, exp);
      end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_n[i]   = 0;
      m_tc[i]  = 0;
    end
  endtask

  // One clock: check tick before the edge, advance the model, check after.
  task automatic cycle();
    bit tk [3];
    #1;
    for (int i = 0; i < 3; i++) begin
      tk[i] = (rst === 1'b1) && (en === 1'b1) && ((m_n[i] % DIVS[i]) == DIVS[i] - 1);
      chk("tick", i, {31'b0, tick_o[i]}, {31'b0, tk[i]});
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (load === 1'b1) begin
        m_cnt[i] = (int'(lv) >= MODS[i]) ? MODS[i] - 1 : int'(lv);
        m_n[i]   = 0;
        m_tc[i]  = 0;
      end else begin
        if (tk[i]) begin
          if (up === 1'b1) begin
            m_tc[i]  = (m_cnt[i] == MODS[i] - 1) ? 1 : 0;
            m_cnt[i] = SATS[i] ? ((m_cnt[i] + 1 > MODS[i] - 1) ? MODS[i] - 1 : m_cnt[i] + 1)
                               : (m_cnt[i] + 1) % MODS[i];
          end else begin
            m_tc[i]  = (m_cnt[i] == 0) ? 1 : 0;
            m_cnt[i] = SATS[i] ? ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1)
                               : (m_cnt[i] + MODS[i] - 1) % MODS[i];
          end
        end else begin
          m_tc[i] = 0;
        end
        if (en === 1'b1) m_n[i]++;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("count", i, {28'b0, cnt_o[i]}, m_cnt[i]);
      chk("tc", i, {31'b0, tc_o[i]}, m_tc[i]);
    end
  endtask

  // Called at posedge+1; asserts reset mid-period and checks it acts at once.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk("rst_count", i, {28'b0, cnt_o[i]}, 0);
      chk("rst_tc", i, {31'b0, tc_o[i]}, 0);
      chk("rst_tick", i, {31'b0, tick_o[i]}, 0);
    end
    @(posedge clk);
    #1;
    chk("rst_hold_count", 0, {28'b0, cnt_o[0]}, 0);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    int k;
    rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; lv = '0;
    model_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("reset_count", i, {28'b0, cnt_o[i]}, 0);
      chk("reset_tc", i, {31'b0, tc_o[i]}, 0);
      chk("reset_tick", i, {31'b0, tick_o[i]}, 0);
    end
    rst = 1'b1;

    // Count up; measure one full revolution between tc pulses of the wrap unit.
    k = 0;
    while (tc_o[0] !== 1'b1 && k < 60) begin cycle(); k++; end
    chk("first_tc_seen", 0, {31'b0, tc_o[0]}, 1);
    k = 0;
    do begin cycle(); k++; end while (tc_o[0] !== 1'b1 && k < 100);
    chk("rev_cycles", 0, k, 40);

    // Saturating unit is held at 9; reversing gives 8 on the next tick, no tc.
    up = 1'b0;
    k = 0;
    while (tick_o[1] !== 1'b1 && k < 10) begin cycle(); k++; end
    cycle();
    chk("sat_down", 1, {28'b0, cnt_o[1]}, 8);
    chk("sat_down_tc", 1, {31'b0, tc_o[1]}, 0);

    // Count down from reset: 0 -> 9 with tc, then 8..0.
    async_reset();
    up = 1'b0;
    repeat (45) cycle();

    // Load coinciding with a tick wins; next step comes 4 cycles later.
    up = 1'b1;
    k = 0;
    while (tick_o[0] !== 1'b1 && k < 10) begin cycle(); k++; end
    chk("tick_before_load", 0, {31'b0, tick_o[0]}, 1);
    load = 1'b1; lv = 4'd5;
    cycle();
    load = 1'b0;
    chk("load_val", 0, {28'b0, cnt_o[0]}, 5);
    repeat (4) cycle();
    chk("after_load_step", 0, {28'b0, cnt_o[0]}, 6);
    load = 1'b1; lv = 4'd15;
    cycle();
    load = 1'b0;
    chk("load_clamp", 0, {28'b0, cnt_o[0]}, 9);
    chk("load_no_clamp", 2, {28'b0, cnt_o[2]}, 15);

    // Pause with pre at 2 for 7 cycles, then resume mid-period.
    repeat (2) cycle();
    en = 1'b0;
    repeat (7) cycle();
    en = 1'b1;
    cycle();
    chk("resume_tick", 0, {31'b0, tick_o[0]}, 1);
    repeat (5) cycle();

    // Reset mid-sequence; the first step afterwards takes exactly DIV cycles.
    async_reset();
    up = 1'b1;
    repeat (3) cycle();
    chk("post_rst_nostep", 0, {28'b0, cnt_o[0]}, 0);
    cycle();
    chk("post_rst_step", 0, {28'b0, cnt_o[0]}, 1);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      load = ($urandom_range(0, 24) == 0);
      lv   = 4'($urandom_range(0, 15));
      cycle();
      load = 1'b0;
      if ($urandom_range(0, 249) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
